upper_triangular_expand: RTL and testbench

//  Receive side of the packed upper-triangular stream produced by upper_triangular.

---
 rtl/upper_triangular_expand_if.sv | 22 ++
 rtl/upper_triangular_expand.sv | 71 +++++++
 tb/tb_upper_triangular_expand.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/upper_triangular_expand_if.sv
// upper_triangular_expand_if: packed-in / expanded-out valid-ready stream pair
interface upper_triangular_expand_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] in_tdata;
    logic                  in_tvalid;
    logic                  in_tready;
    logic [DATA_WIDTH-1:0] out_tdata;
    logic                  out_tready;
    logic                  out_tvalid;
    logic                  out_tlast;

    modport master (
        output in_tdata, in_tvalid, out_tready,
        input  in_tready, out_tdata, out_tvalid, out_tlast
    );

    modport slave (
        input  in_tdata, in_tvalid, out_tready,
        output in_tready, out_tdata, out_tvalid, out_tlast
    );
endinterface

// File: rtl/upper_triangular_expand.sv
// upper_triangular_expand: re-expands a packed upper-triangle stream into a full row-major matrix
module upper_triangular_expand #(
    parameter int SIZE       = 4,
    parameter int DATA_WIDTH = 32
) (
    input logic                      clk,
    input logic                      rst,
    upper_triangular_expand_if.slave bus
);
    localparam int CW = $clog2(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic {FILL, ZERO} state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_row, r_col, w_row_nxt, w_col_nxt;
    logic [DATA_WIDTH-1:0] r_tdata, w_tdata_nxt;
    logic                  r_tvalid, r_tlast;
    logic                  w_load_en, w_in_tready, w_load;

    assign w_load_en = !r_tvalid || bus.out_tready;

    // Pick the slot source (input or zero), decide whether a beat loads, and step the position
    always_comb begin
        w_in_tready = 1'b0;
        w_load      = 1'b0;
        w_tdata_nxt = '0;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_state_nxt = r_state;
        if (r_state == FILL) begin
            w_in_tready = rst && w_load_en;
            w_load      = w_in_tready && bus.in_tvalid;
            w_tdata_nxt = bus.in_tdata;
        end else begin
            w_load = w_load_en;
        end
        if (w_load) begin
            w_col_nxt   = (r_col == LAST) ? '0 : r_col + 1'b1;
            w_row_nxt   = (r_col != LAST) ? r_row : (r_row == LAST) ? '0 : r_row + 1'b1;
            w_state_nxt = (w_col_nxt >= w_row_nxt) ? FILL : ZERO;
        end
    end

    // Position/state register and the single output beat register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= FILL;
            r_row    <= '0;
            r_col    <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else if (w_load) begin
            r_state  <= w_state_nxt;
            r_row    <= w_row_nxt;
            r_col    <= w_col_nxt;
            r_tdata  <= w_tdata_nxt;
            r_tvalid <= 1'b1;
            r_tlast  <= (r_row == LAST) && (r_col == LAST);
        end else if (r_tvalid && bus.out_tready) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end
    end

    assign bus.in_tready  = w_in_tready;
    assign bus.out_tdata  = r_tdata;
    assign bus.out_tvalid = r_tvalid;
    assign bus.out_tlast  = r_tlast;
endmodule

// File: tb/tb_upper_triangular_expand.sv
// tb_upper_triangular_expand: randomized checks of the triangle expander against a matrix model
module tb_upper_triangular_expand;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    upper_triangular_expand_if #(.DATA_WIDTH(32)) if4 ();
    upper_triangular_expand_if #(.DATA_WIDTH(32)) if2 ();

    upper_triangular_expand #(.SIZE(4), .DATA_WIDTH(32)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    upper_triangular_expand #(.SIZE(2), .DATA_WIDTH(32)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic [31:0] stim[$];
    logic [31:0] exp_d[$];
    bit          exp_l[$];
    logic [31:0] q4_d[$];
    bit          q4_l[$];
    logic [31:0] q2_d[$];
    bit          q2_l[$];
    logic [31:0] hold_d[$];
    bit          hold_r[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          lowcnt = 0;
    bit          active = 1'b0;
    bit          acc4 = 1'b0;
    bit          acc2 = 1'b0;
    bit          to;

    // Observe mid-cycle what the coming rising edge will transfer
    always @(negedge clk) begin
        if (if4.out_tvalid && if4.out_tready) begin
            q4_d.push_back(if4.out_tdata);
            q4_l.push_back(if4.out_tlast);
        end
        if (if4.out_tvalid && !if4.out_tready) begin
            hold_d.push_back(if4.out_tdata);
            hold_r.push_back(if4.in_tready);
        end
        if (if2.out_tvalid && if2.out_tready) begin
            q2_d.push_back(if2.out_tdata);
            q2_l.push_back(if2.out_tlast);
        end
        if (active && !if4.in_tready) lowcnt++;
        acc4 = if4.in_tvalid && if4.in_tready;
        acc2 = if2.in_tvalid && if2.in_tready;
    end

    // Reference: walk every slot of each matrix, take the next packed element on/above the diagonal
    task automatic build_exp(input int s);
        int k = 0;
        exp_d.delete();
        exp_l.delete();
        while (k < stim.size()) begin
            for (int r = 0; r < s; r++) begin
                for (int c = 0; c < s; c++) begin
                    exp_d.push_back(c >= r ? stim[k] : 32'd0);
                    if (c >= r) k++;
                    exp_l.push_back(r == s - 1 && c == s - 1);
                end
            end
        end
    endtask

    function automatic int n_out_of(input int s, input int n_in);
        return n_in / (s * (s + 1) / 2) * s * s;
    endfunction

    task automatic fill_seq(input int first, input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(32'(first + i));
    endtask

    // Stream stim into one instance; vprob<0 means valid on alternate cycles; stall_val>=0 holds that beat 2 cycles
    task automatic drive(input int sel, input int vprob, input int rprob, input int stall_val,
                         input int n_out, output bit timed_out);
        int idx = 0;
        int cyc = 0;
        int scnt = 0;
        logic vld, rdy;
        logic [31:0] dat;
        q4_d.delete(); q4_l.delete(); q2_d.delete(); q2_l.delete();
        hold_d.delete(); hold_r.delete();
        lowcnt = 0;
        active = 1'b1;
        while ((idx < stim.size() || (sel == 4 ? q4_d.size() : q2_d.size()) < n_out) && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (sel == 4 ? acc4 : acc2) idx++;
            vld = idx < stim.size() && (vprob < 0 ? (cyc % 2 == 0) : ($urandom_range(99) < vprob));
            dat = idx < stim.size() ? stim[idx] : 32'd0;
            rdy = $urandom_range(99) < rprob;
            if (sel == 4 && stall_val >= 0 && if4.out_tvalid && if4.out_tdata == 32'(stall_val) && scnt < 2) begin
                rdy = 1'b0;
                scnt++;
            end
            if (sel == 4) begin
                if4.in_tvalid = vld; if4.in_tdata = dat; if4.out_tready = rdy;
            end else begin
                if2.in_tvalid = vld; if2.in_tdata = dat; if2.out_tready = rdy;
            end
        end
        active = 1'b0;
        if4.in_tvalid = 1'b0;
        if2.in_tvalid = 1'b0;
        if4.out_tready = 1'b1;
        if2.out_tready = 1'b1;
        timed_out = cyc >= 2000;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({if4.out_tvalid, if4.out_tlast, if4.in_tready} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctl: got v/l/rdy=%b%b%b want 000", if4.out_tvalid, if4.out_tlast, if4.in_tready);
        end
        n_cmp++;
        if (if4.out_tdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", if4.out_tdata);
        end
        n_cmp++;
        if ({if2.out_tvalid, if2.in_tready} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_size2: got v/rdy=%b%b want 00", if2.out_tvalid, if2.in_tready);
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_basic;
        fill_seq(1, 10);
        build_exp(4);
        drive(4, 100, 100, -1, 16, to);
        n_cmp++;
        if (to || q4_d.size() != exp_d.size()) begin
            n_err++;
            $display("FAIL basic_count: got %0d beats (timeout=%0b) want %0d", q4_d.size(), to, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < q4_d.size(); i++) begin
            n_cmp++;
            if (q4_d[i] !== exp_d[i] || q4_l[i] !== exp_l[i]) begin
                n_err++;
                $display("FAIL basic beat %0d: got %h/%b want %h/%b", i, q4_d[i], q4_l[i], exp_d[i], exp_l[i]);
            end
        end
        n_cmp++;
        if (lowcnt != 6) begin
            n_err++;
            $display("FAIL basic_ready_low: got %0d cycles want 6", lowcnt);
        end
    endtask

    task automatic test_stall;
        fill_seq(1, 10);
        build_exp(4);
        drive(4, 100, 100, 6, 16, to);
        n_cmp++;
        if (to || q4_d.size() != exp_d.size()) begin
            n_err++;
            $display("FAIL stall_count: got %0d beats (timeout=%0b) want %0d", q4_d.size(), to, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < q4_d.size(); i++) begin
            n_cmp++;
            if (q4_d[i] !== exp_d[i] || q4_l[i] !== exp_l[i]) begin
                n_err++;
                $display("FAIL stall beat %0d: got %h/%b want %h/%b", i, q4_d[i], q4_l[i], exp_d[i], exp_l[i]);
            end
        end
        n_cmp++;
        if (hold_d.size() != 2) begin
            n_err++;
            $display("FAIL stall_hold_cycles: got %0d want 2", hold_d.size());
        end
        for (int i = 0; i < hold_d.size(); i++) begin
            n_cmp++;
            if (hold_d[i] !== 32'd6 || hold_r[i] !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold %0d: got data %h rdy %b want 6/0", i, hold_d[i], hold_r[i]);
            end
        end
    endtask

    task automatic test_sparse_valid;
        fill_seq(1, 10);
        build_exp(4);
        drive(4, -1, 100, -1, 16, to);
        n_cmp++;
        if (to || q4_d.size() != exp_d.size()) begin
            n_err++;
            $display("FAIL sparse_count: got %0d beats (timeout=%0b) want %0d", q4_d.size(), to, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < q4_d.size(); i++) begin
            n_cmp++;
            if (q4_d[i] !== exp_d[i] || q4_l[i] !== exp_l[i]) begin
                n_err++;
                $display("FAIL sparse beat %0d: got %h/%b want %h/%b", i, q4_d[i], q4_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        fill_seq(11, 30);
        for (int i = 0; i < 30; i++) stim[i] = 32'(i + 1);
        build_exp(4);
        drive(4, 100, 100, -1, 48, to);
        n_cmp++;
        if (to || q4_d.size() != 48) begin
            n_err++;
            $display("FAIL b2b_count: got %0d beats (timeout=%0b) want 48", q4_d.size(), to);
        end
        for (int i = 0; i < exp_d.size() && i < q4_d.size(); i++) begin
            n_cmp++;
            if (q4_d[i] !== exp_d[i] || q4_l[i] !== exp_l[i]) begin
                n_err++;
                $display("FAIL b2b beat %0d: got %h/%b want %h/%b", i, q4_d[i], q4_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_random;
        stim.delete();
        for (int i = 0; i < 50; i++) stim.push_back($urandom);
        build_exp(4);
        drive(4, 60, 55, -1, 80, to);
        n_cmp++;
        if (to || q4_d.size() != exp_d.size()) begin
            n_err++;
            $display("FAIL random_count: got %0d beats (timeout=%0b) want %0d", q4_d.size(), to, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < q4_d.size(); i++) begin
            n_cmp++;
            if (q4_d[i] !== exp_d[i] || q4_l[i] !== exp_l[i]) begin
                n_err++;
                $display("FAIL random beat %0d: got %h/%b want %h/%b", i, q4_d[i], q4_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        fill_seq(1, 6);
        drive(4, 100, 100, -1, 7, to);
        n_cmp++;
        if (to || q4_d.size() != 7) begin
            n_err++;
            $display("FAIL rstmid_prefix: got %0d beats (timeout=%0b) want 7", q4_d.size(), to);
        end
        if4.out_tready = 1'b0;
        if4.in_tvalid  = 1'b1;
        if4.in_tdata   = 32'd77;
        @(posedge clk);
        #1;
        n_cmp++;
        if (if4.out_tvalid !== 1'b1 || if4.out_tdata !== 32'd77) begin
            n_err++;
            $display("FAIL rstmid_held: got v=%b data %h want 1/77", if4.out_tvalid, if4.out_tdata);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (if4.in_tready !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_ready: got %b want 0", if4.in_tready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({if4.out_tvalid, if4.out_tlast} !== 2'b00 || if4.out_tdata !== 32'd0) begin
            n_err++;
            $display("FAIL rstmid_cleared: got v/l=%b%b data %h want 00/0", if4.out_tvalid, if4.out_tlast, if4.out_tdata);
        end
        rst = 1'b1;
        if4.in_tvalid  = 1'b0;
        if4.out_tready = 1'b1;
        fill_seq(100, 10);
        build_exp(4);
        drive(4, 100, 100, -1, 16, to);
        n_cmp++;
        if (to || q4_d.size() != exp_d.size()) begin
            n_err++;
            $display("FAIL rstmid_count: got %0d beats (timeout=%0b) want %0d", q4_d.size(), to, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < q4_d.size(); i++) begin
            n_cmp++;
            if (q4_d[i] !== exp_d[i] || q4_l[i] !== exp_l[i]) begin
                n_err++;
                $display("FAIL rstmid beat %0d: got %h/%b want %h/%b", i, q4_d[i], q4_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_size2;
        stim.delete();
        for (int i = 0; i < 9; i++) stim.push_back($urandom | 32'd1);
        build_exp(2);
        drive(2, 70, 70, -1, 12, to);
        n_cmp++;
        if (to || q2_d.size() != exp_d.size()) begin
            n_err++;
            $display("FAIL size2_count: got %0d beats (timeout=%0b) want %0d", q2_d.size(), to, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < q2_d.size(); i++) begin
            n_cmp++;
            if (q2_d[i] !== exp_d[i] || q2_l[i] !== exp_l[i]) begin
                n_err++;
                $display("FAIL size2 beat %0d: got %h/%b want %h/%b", i, q2_d[i], q2_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    initial begin
        if4.in_tvalid = 1'b0; if4.in_tdata = '0; if4.out_tready = 1'b1;
        if2.in_tvalid = 1'b0; if2.in_tdata = '0; if2.out_tready = 1'b1;
        test_reset;
        test_basic;
        test_stall;
        test_sparse_valid;
        test_back_to_back;
        test_random;
        test_reset_mid;
        test_size2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
